// File: rtl/side_info_pkg.sv
// Shared types for the MPEG-1 Layer III side-info parser:
// FSM encodings, frame sizes, granule fields and the granule unpacker.
package side_info_pkg;

    localparam int MONO_BYTES   = 17;
    localparam int STEREO_BYTES = 32;
    localparam int GR_BITS      = 59;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE     = 3'd0;
    localparam state_t S_CRC_SKIP = 3'd1;
    localparam state_t S_COLLECT  = 3'd2;
    localparam state_t S_DECODE   = 3'd3;
    localparam state_t S_DONE     = 3'd4;

    typedef struct packed {
        logic [11:0]     part2_3_length;
        logic [8:0]      big_values;
        logic [7:0]      global_gain;
        logic [3:0]      scalefac_compress;
        logic            window_switching_flag;
        logic [1:0]      block_type;
        logic            mixed_block_flag;
        logic [2:0][4:0] table_select;
        logic [2:0][2:0] subblock_gain;
        logic [3:0]      region0_count;
        logic [5:0]      region1_count;
        logic            preflag;
        logic            scalefac_scale;
        logic            count1table_select;
    } gr_ch_t;

    // Switched windows carry no region counts; they take the fixed defaults.
    function automatic gr_ch_t unpack_gr(input logic [GR_BITS-1:0] g);
        gr_ch_t r;
        r = '0;
        r.part2_3_length        = g[58:47];
        r.big_values            = g[46:38];
        r.global_gain           = g[37:30];
        r.scalefac_compress     = g[29:26];
        r.window_switching_flag = g[25];
        if (g[25]) begin
            r.block_type       = g[24:23];
            r.mixed_block_flag = g[22];
            r.table_select[0]  = g[21:17];
            r.table_select[1]  = g[16:12];
            r.subblock_gain[0] = g[11:9];
            r.subblock_gain[1] = g[8:6];
            r.subblock_gain[2] = g[5:3];
            r.region0_count    = (g[24:23] == 2'd2 && !g[22]) ? 4'd8 : 4'd7;
            r.region1_count    = 6'd36;
        end else begin
            r.table_select[0] = g[24:20];
            r.table_select[1] = g[19:15];
            r.table_select[2] = g[14:10];
            r.region0_count   = g[9:6];
            r.region1_count   = {3'b000, g[5:3]};
        end
        r.preflag            = g[2];
        r.scalefac_scale     = g[1];
        r.count1table_select = g[0];
        return r;
    endfunction

endpackage

// File: rtl/side_info_parser_if.sv
// Byte stream in, decoded side-info fields out.
// master drives the stream and header flags; slave is the parser.
interface side_info_parser_if #(
    parameter int MAX_CH = 2,
    parameter int N_GR   = 2
);
    logic                              frame_start;
    logic                              mono;
    logic                              crc_present;
    logic [7:0]                        axiid;
    logic                              axiiv;
    logic [15:0]                       hdr_crc_bytes;
    logic [8:0]                        main_data_begin;
    logic [MAX_CH-1:0][3:0]            scfsi;
    logic [N_GR-1:0][MAX_CH-1:0][11:0] part2_3_length;
    logic [N_GR-1:0][MAX_CH-1:0][8:0]  big_values;
    logic [N_GR-1:0][MAX_CH-1:0][7:0]  global_gain;
    logic [N_GR-1:0][MAX_CH-1:0][3:0]  scalefac_compress;
    logic [N_GR-1:0][MAX_CH-1:0]       window_switching_flag;
    logic [N_GR-1:0][MAX_CH-1:0][1:0]  block_type;
    logic [N_GR-1:0][MAX_CH-1:0]       mixed_block_flag;
    logic [N_GR-1:0][MAX_CH-1:0][2:0][4:0] table_select;
    logic [N_GR-1:0][MAX_CH-1:0][2:0][2:0] subblock_gain;
    logic [N_GR-1:0][MAX_CH-1:0][3:0]  region0_count;
    logic [N_GR-1:0][MAX_CH-1:0][5:0]  region1_count;
    logic [N_GR-1:0][MAX_CH-1:0]       preflag;
    logic [N_GR-1:0][MAX_CH-1:0]       scalefac_scale;
    logic [N_GR-1:0][MAX_CH-1:0]       count1table_select;
    logic                              side_valid;
    logic                              busy;
    logic                              crc_err;
    logic                              fmt_err;

    modport master (
        output frame_start, mono, crc_present, axiid, axiiv, hdr_crc_bytes,
        input  main_data_begin, scfsi, part2_3_length, big_values,
        input  global_gain, scalefac_compress, window_switching_flag,
        input  block_type, mixed_block_flag, table_select, subblock_gain,
        input  region0_count, region1_count, preflag, scalefac_scale,
        input  count1table_select, side_valid, busy, crc_err, fmt_err
    );

    modport slave (
        input  frame_start, mono, crc_present, axiid, axiiv, hdr_crc_bytes,
        output main_data_begin, scfsi, part2_3_length, big_values,
        output global_gain, scalefac_compress, window_switching_flag,
        output block_type, mixed_block_flag, table_select, subblock_gain,
        output region0_count, region1_count, preflag, scalefac_scale,
        output count1table_select, side_valid, busy, crc_err, fmt_err
    );

endinterface

// File: rtl/side_info_parser_crc16_byte.sv
// One-byte CRC-16 step, polynomial 0x8005, MSB first, no reflection.
module crc16_byte (
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);
    logic [15:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h8005;
            else                 c = {c[14:0], 1'b0};
        end
        crc_out = c;
    end
endmodule

// File: rtl/side_info_parser.sv
// MPEG-1 Layer III side-info parser (mono 17 B / stereo 32 B).
// Define SIDE_CRC_EN to check the frame CRC-16 over header and side info.
module side_info_parser
    import side_info_pkg::*;
#(
    parameter int MAX_CH  = 2,
    parameter int N_GR    = 2,
    parameter int SI_BITS = 256
) (
    input logic                clk,
    input logic                rst,
    side_info_parser_if.slave  bus
);
    state_t             state;
    logic [5:0]         cnt;
    logic [SI_BITS-1:0] sr;
    logic               mono_q;
    logic               crc_p;
    logic [8:0]         mdb_q;
    logic [1:0][3:0]    scfsi_q;
    gr_ch_t             gr_q [2][2];
    logic               valid_q;
    logic               fmt_err_q;
    logic               crc_err_q;
    logic               last;
    logic               unused_bits;

    assign last = cnt == (mono_q ? 6'(MONO_BYTES - 1) : 6'(STEREO_BYTES - 1));
    assign unused_bits = ^sr[246:244];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            sr        <= '0;
            mono_q    <= 1'b0;
            crc_p     <= 1'b0;
            mdb_q     <= '0;
            scfsi_q   <= '0;
            valid_q   <= 1'b0;
            fmt_err_q <= 1'b0;
            for (int g = 0; g < 2; g++)
                for (int c = 0; c < 2; c++)
                    gr_q[g][c] <= '0;
        end else if (bus.frame_start) begin
            // Restart wins over any beat arriving in the same cycle.
            state     <= bus.crc_present ? S_CRC_SKIP : S_COLLECT;
            cnt       <= '0;
            sr        <= '0;
            mono_q    <= bus.mono;
            crc_p     <= bus.crc_present;
            mdb_q     <= '0;
            scfsi_q   <= '0;
            valid_q   <= 1'b0;
            fmt_err_q <= 1'b0;
            for (int g = 0; g < 2; g++)
                for (int c = 0; c < 2; c++)
                    gr_q[g][c] <= '0;
        end else begin
            unique case (state)
                S_CRC_SKIP: if (bus.axiiv) begin
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd1) begin
                        cnt   <= '0;
                        state <= S_COLLECT;
                    end
                end
                S_COLLECT: if (bus.axiiv) begin
                    sr  <= {sr[SI_BITS-9:0], bus.axiid};
                    cnt <= cnt + 6'd1;
                    if (last) begin
                        cnt   <= '0;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    state   <= S_DONE;
                    valid_q <= 1'b1;
                    if (!mono_q && MAX_CH == 1) begin
                        fmt_err_q <= 1'b1;
                    end else if (mono_q) begin
                        mdb_q      <= sr[135:127];
                        scfsi_q[0] <= sr[121:118];
                        gr_q[0][0] <= unpack_gr(sr[117:59]);
                        gr_q[1][0] <= unpack_gr(sr[58:0]);
                    end else begin
                        mdb_q      <= sr[255:247];
                        scfsi_q[0] <= sr[243:240];
                        scfsi_q[1] <= sr[239:236];
                        gr_q[0][0] <= unpack_gr(sr[235:177]);
                        gr_q[0][1] <= unpack_gr(sr[176:118]);
                        gr_q[1][0] <= unpack_gr(sr[117:59]);
                        gr_q[1][1] <= unpack_gr(sr[58:0]);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SIDE_CRC_EN
    logic [15:0] crc_q;
    logic [15:0] rx_q;
    logic [15:0] crc_h0;
    logic [15:0] crc_h1;
    logic [15:0] crc_d;

    crc16_byte u_h0 (.crc_in(16'hFFFF), .data(bus.hdr_crc_bytes[15:8]), .crc_out(crc_h0));
    crc16_byte u_h1 (.crc_in(crc_h0), .data(bus.hdr_crc_bytes[7:0]), .crc_out(crc_h1));
    crc16_byte u_d  (.crc_in(crc_q), .data(bus.axiid), .crc_out(crc_d));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q     <= '0;
            rx_q      <= '0;
            crc_err_q <= 1'b0;
        end else if (bus.frame_start) begin
            crc_q     <= crc_h1;
            rx_q      <= '0;
            crc_err_q <= 1'b0;
        end else if (state == S_CRC_SKIP && bus.axiiv) begin
            rx_q <= {rx_q[7:0], bus.axiid};
        end else if (state == S_COLLECT && bus.axiiv) begin
            crc_q <= crc_d;
        end else if (state == S_DECODE) begin
            crc_err_q <= crc_p && (crc_q != rx_q);
        end
    end
`else
    logic unused_crc;
    assign unused_crc = ^{bus.hdr_crc_bytes, crc_p};
    assign crc_err_q  = 1'b0;
`endif

    always_comb begin
        bus.main_data_begin       = mdb_q;
        bus.side_valid            = valid_q;
        bus.busy                  = !(state == S_IDLE || state == S_DONE);
        bus.crc_err               = crc_err_q;
        bus.fmt_err               = fmt_err_q;
        bus.scfsi                 = '0;
        bus.part2_3_length        = '0;
        bus.big_values            = '0;
        bus.global_gain           = '0;
        bus.scalefac_compress     = '0;
        bus.window_switching_flag = '0;
        bus.block_type            = '0;
        bus.mixed_block_flag      = '0;
        bus.table_select          = '0;
        bus.subblock_gain         = '0;
        bus.region0_count         = '0;
        bus.region1_count         = '0;
        bus.preflag               = '0;
        bus.scalefac_scale        = '0;
        bus.count1table_select    = '0;
        for (int c = 0; c < MAX_CH; c++) bus.scfsi[c] = scfsi_q[c];
        for (int g = 0; g < N_GR; g++) begin
            for (int c = 0; c < MAX_CH; c++) begin
                bus.part2_3_length[g][c]        = gr_q[g][c].part2_3_length;
                bus.big_values[g][c]            = gr_q[g][c].big_values;
                bus.global_gain[g][c]           = gr_q[g][c].global_gain;
                bus.scalefac_compress[g][c]     = gr_q[g][c].scalefac_compress;
                bus.window_switching_flag[g][c] = gr_q[g][c].window_switching_flag;
                bus.block_type[g][c]            = gr_q[g][c].block_type;
                bus.mixed_block_flag[g][c]      = gr_q[g][c].mixed_block_flag;
                bus.table_select[g][c]          = gr_q[g][c].table_select;
                bus.subblock_gain[g][c]         = gr_q[g][c].subblock_gain;
                bus.region0_count[g][c]         = gr_q[g][c].region0_count;
                bus.region1_count[g][c]         = gr_q[g][c].region1_count;
                bus.preflag[g][c]               = gr_q[g][c].preflag;
                bus.scalefac_scale[g][c]        = gr_q[g][c].scalefac_scale;
                bus.count1table_select[g][c]    = gr_q[g][c].count1table_select;
            end
        end
    end

endmodule
